// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the serial BCD adder.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_ADJ     = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    // Wraps for illegal digits; the result is flagged by err anyway.
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal carry in/out.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_d,
    input  logic [BCD_DIGIT_W-1:0] b_d,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] s_d,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a_d} + {1'b0, b_d} + {{BCD_DIGIT_W{1'b0}}, cin};
        if (raw > {1'b0, BCD_MAX}) begin
            s_d  = raw[BCD_DIGIT_W-1:0] + BCD_ADJ;
            cout = 1'b1;
        end else begin
            s_d  = raw[BCD_DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder: one digit per clock, LSD first, valid/ready on both sides.
// Optional macro BCD_SUB_EN adds an op port selecting ten's-complement subtraction.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef BCD_SUB_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    bcd_state_t            state;
    logic [W-1:0]          a_sh, b_sh, sum_r;
    logic [CW-1:0]         cnt;
    logic                  carry, err_r, in_ready_r, out_valid_r;
    logic [BCD_DIGIT_W-1:0] b_dig, s_d;
    logic                  dig_cout;
    logic [W-1:0]          sum_next;
    logic                  accept, start_carry;

    function automatic logic has_illegal(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (v[4*k +: 4] > BCD_MAX) bad = 1'b1;
        return bad;
    endfunction

`ifdef BCD_SUB_EN
    logic sub_r;
    assign b_dig       = sub_r ? nines_comp(b_sh[BCD_DIGIT_W-1:0]) : b_sh[BCD_DIGIT_W-1:0];
    assign start_carry = op;
`else
    assign b_dig       = b_sh[BCD_DIGIT_W-1:0];
    assign start_carry = 1'b0;
`endif

    bcd_digit_add u_dig (
        .a_d  (a_sh[BCD_DIGIT_W-1:0]),
        .b_d  (b_dig),
        .cin  (carry),
        .s_d  (s_d),
        .cout (dig_cout)
    );

    // New digit enters at the top; after DIGITS shifts the first one sits at the bottom.
    assign sum_next = (sum_r >> BCD_DIGIT_W) | (W'(s_d) << (W - BCD_DIGIT_W));
    assign accept   = in_valid && in_ready_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_r       <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef BCD_SUB_EN
            sub_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh       <= a;
                        b_sh       <= b;
                        sum_r      <= '0;
                        cnt        <= '0;
                        carry      <= start_carry;
                        err_r      <= has_illegal(a) | has_illegal(b);
                        in_ready_r <= 1'b0;
`ifdef BCD_SUB_EN
                        sub_r      <= op;
`endif
                        state      <= ADD;
                    end
                end
                ADD: begin
                    a_sh  <= a_sh >> BCD_DIGIT_W;
                    b_sh  <= b_sh >> BCD_DIGIT_W;
                    sum_r <= sum_next;
                    carry <= dig_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = carry;
    assign err       = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: directed vector table, corner sequences, random ops vs decimal model.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef BCD_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
        logic        err;
        logic        chk_sum;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [15:0] v);
        for (int k = 0; k < DIGITS; k++) if (v[4*k +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: plain decimal arithmetic on the operand values.
    task automatic model(input logic [15:0] xa, input logic [15:0] xb, input logic sub,
                         output logic [15:0] es, output logic ec, output logic ee);
        int r;
        if (sub) r = bcd2int(xa) - bcd2int(xb);
        else     r = bcd2int(xa) + bcd2int(xb);
        if (sub) begin
            ec = (r >= 0);
            es = int2bcd(r >= 0 ? r : 10000 + r);
        end else begin
            ec = (r >= 10000);
            es = int2bcd(r % 10000);
        end
        ee = any_bad(xa) | any_bad(xb);
    endtask

    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb, input logic xop);
        int guard = 0;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        a = xa; b = xb; op = xop; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready after handshake", 32'(in_ready), 32'd1);
        chk("out_valid after handshake", 32'(out_valid), 32'd0);
    endtask

    task automatic run_check(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                             input logic xop, input logic chk_sum,
                             input logic [15:0] es, input logic ec, input logic ee);
        int lat;
        start_op(xa, xb, xop);
        wait_done(lat);
        chk({nm, " latency"}, 32'(lat), 32'(DIGITS));
        if (chk_sum) begin
            chk({nm, " sum"}, 32'(sum), 32'(es));
            chk({nm, " cout"}, 32'(cout), 32'(ec));
        end
        chk({nm, " err"}, 32'(err), 32'(ee));
        finish_op();
    endtask

    initial begin
        vec_t vecs[8];
        logic [15:0] es, xa, xb;
        logic ec, ee, stable;
        int lat;

        vecs[0] = '{16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, vecs[i].chk_sum,
                      vecs[i].sum, vecs[i].cout, vecs[i].err);

        // Back-pressure: outputs frozen while out_ready stays low.
        start_op(16'h4321, 16'h1111, 1'b0);
        stable = 1'b1;
        for (int c = 0; c < DIGITS - 1; c++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0) stable = 1'b0;
        end
        wait_done(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || sum !== 16'h5432 || cout !== 1'b0 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("backpressure stable", 32'(stable), 32'd1);
        chk("backpressure sum", 32'(sum), 32'h5432);
        finish_op();

        // Reset during the second ADD cycle drops the transaction.
        start_op(16'h7777, 16'h2222, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset sum", 32'(sum), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_check("after reset", 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
        run_check("sub pos", 16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0);
        run_check("sub neg", 16'h0123, 16'h0500, 1'b1, 1'b1, 16'h9623, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic sub;
            xa = '0; xb = '0;
            for (int k = 0; k < DIGITS; k++) begin
                xa[4*k +: 4] = 4'($urandom_range(0, 9));
                xb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) xa[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            sub = 1'b0;
`ifdef BCD_SUB_EN
            sub = 1'($urandom_range(0, 1));
`endif
            model(xa, xb, sub, es, ec, ee);
            run_check($sformatf("rand%0d", i), xa, xb, sub, !ee, es, ec, ee);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
